// File: rtl/mult_pkg.sv
// Shared types and helpers for the integer multiply pipeline.
// Stage bundles, tracker entry type and sign/magnitude conversion.
package mult_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MUL_DEPTH  = 3;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] regdest;
  } mult_dest_t;

  typedef struct packed {
    logic                  oper;
    logic [MUL_DATA_W-1:0] rs_mag;
    logic [MUL_DATA_W-1:0] rt_mag;
    logic [4:0]            regdest;
    logic                  ispositive;
    logic                  iszero;
  } m1_m2_t;

  // Most negative value maps onto itself, which is the right
  // unsigned magnitude.
  function automatic logic [MUL_DATA_W-1:0] mag_of(
    input logic [MUL_DATA_W-1:0] value
  );
    if (value[MUL_DATA_W-1])
      return ~value + MUL_DATA_W'(1);
    return value;
  endfunction

endpackage

// File: rtl/mult_dest_tracker.sv
// In-flight destination tracker for the multiply pipeline.
// Shift register of destinations plus decode hazard match.
module mult_dest_tracker
  import mult_pkg::*;
#(
  parameter int DEPTH = MUL_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid_i,
  input  logic [4:0]       push_dest_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  output logic             hazard_o,
  output logic [CNT_W-1:0] count_o
);

  mult_dest_t ent_q [DEPTH];
  mult_dest_t ent_d [DEPTH];

  // Shift one slot per cycle; r0 writes never need tracking.
  always_comb begin
    ent_d[0].valid   = push_valid_i
                       && (push_dest_i != REG_ZERO);
    ent_d[0].regdest = push_dest_i;
    for (int i = 1; i < DEPTH; i++)
      ent_d[i] = ent_q[i-1];
  end

  // Entry register; reset clears every slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  // Match decode sources and count live entries.
  always_comb begin
    hazard_o = 1'b0;
    count_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        count_o = count_o + CNT_W'(1);
        if (ent_q[i].regdest == rs_addr_i
            || ent_q[i].regdest == rt_addr_i)
          hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_issue.sv
// Multiply front stage: sign/magnitude split and zero detect.
// Registers toward stage 2 and flags decode hazards.
module mult_issue
  import mult_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W,
  parameter int DEPTH  = MUL_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_mul_oper,
  input  logic [DATA_W-1:0] iss_mul_rs_value,
  input  logic [DATA_W-1:0] iss_mul_rt_value,
  input  logic [4:0]        iss_mul_regdest,
  input  logic [4:0]        dec_rs_addr,
  input  logic [4:0]        dec_rt_addr,
  output logic              m1_m2_oper,
  output logic [DATA_W-1:0] m1_m2_rs_mag,
  output logic [DATA_W-1:0] m1_m2_rt_mag,
  output logic [4:0]        m1_m2_regdest,
  output logic              m1_m2_ispositive,
  output logic              m1_m2_iszero,
  output logic              mul_hazard,
  output logic [1:0]        mul_inflight
);

  m1_m2_t stg_q;
  m1_m2_t stg_d;
  logic   zero_c;

  // Build the next stage bundle; idle cycles clear it.
  always_comb begin
    stg_d  = '0;
    zero_c = (iss_mul_rs_value == '0)
             || (iss_mul_rt_value == '0);
    if (iss_mul_oper) begin
      stg_d.oper       = 1'b1;
      stg_d.rs_mag     = mag_of(iss_mul_rs_value);
      stg_d.rt_mag     = mag_of(iss_mul_rt_value);
      stg_d.regdest    = iss_mul_regdest;
      stg_d.iszero     = zero_c;
      stg_d.ispositive = zero_c
        || (iss_mul_rs_value[DATA_W-1]
            == iss_mul_rt_value[DATA_W-1]);
    end
  end

  // M1 stage register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset)
      stg_q <= '0;
    else
      stg_q <= stg_d;
  end

  assign m1_m2_oper       = stg_q.oper;
  assign m1_m2_rs_mag     = stg_q.rs_mag;
  assign m1_m2_rt_mag     = stg_q.rt_mag;
  assign m1_m2_regdest    = stg_q.regdest;
  assign m1_m2_ispositive = stg_q.ispositive;
  assign m1_m2_iszero     = stg_q.iszero;

  mult_dest_tracker #(
    .DEPTH (DEPTH),
    .CNT_W (2)
  ) u_trk (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (iss_mul_oper),
    .push_dest_i  (iss_mul_regdest),
    .rs_addr_i    (dec_rs_addr),
    .rt_addr_i    (dec_rt_addr),
    .hazard_o     (mul_hazard),
    .count_o      (mul_inflight)
  );

endmodule

// File: doc/mult_issue.md
# mult_issue

Front stage of the three-stage integer multiply pipeline, the producing end of the `m*_m*` stage interface that terminates in the writeback stage. It takes a multiply from issue, converts operands to sign/magnitude form, flags a zero product, and registers everything toward stage 2. It also tracks the destination registers of multiplies still in flight and raises a hazard to decode until each result has left the writeback register.

## Interface
Parameters:
- `DATA_W`, 32, operand width; the product is `2*DATA_W`.
- `DEPTH`, 3, number of stage registers between issue and the writeback output (M1, M2, M3).

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `iss_mul_oper`  in  1  a multiply is issued this cycle.
- `iss_mul_rs_value`  in  DATA_W  first operand, two's complement.
- `iss_mul_rt_value`  in  DATA_W  second operand, two's complement.
- `iss_mul_regdest`  in  5  destination register.
- `dec_rs_addr`  in  5  source register of the instruction in decode.
- `dec_rt_addr`  in  5  source register of the instruction in decode.
- `m1_m2_oper`  out  1  stage-2 input valid.
- `m1_m2_rs_mag`  out  DATA_W  |rs|, unsigned.
- `m1_m2_rt_mag`  out  DATA_W  |rt|, unsigned.
- `m1_m2_regdest`  out  5  destination register.
- `m1_m2_ispositive`  out  1  product sign is non-negative.
- `m1_m2_iszero`  out  1  one or both operands are zero.
- `mul_hazard`  out  1  a decode source matches an in-flight destination (combinational).
- `mul_inflight`  out  2  count of valid tracker entries, 0..DEPTH.

## Operation
- **Reset** (`reset`=0 at an edge): all `m1_m2_*` outputs are 0 and every tracker entry is invalid. `mul_hazard` and `mul_inflight` are therefore 0 one cycle after reset. Reset overrides `iss_mul_oper` in the same cycle.
- **Stage register.** On each edge with `iss_mul_oper`=1:
  - `m1_m2_oper` is 1.
  - Magnitude = value if its sign bit is 0, otherwise `~value+1` in DATA_W bits. For 0x8000_0000 this gives 0x8000_0000, which is correct as an unsigned magnitude.
  - `iszero` = (rs==0) | (rt==0).
  - `ispositive` = (rs[31]==rt[31]) | iszero.
  - `regdest` is passed through.
- **Idle cycle.** On an edge with `iss_mul_oper`=0, all `m1_m2_*` outputs are 0. Data does not hold.
- **Tracker.** The tracker is a DEPTH-entry shift register of {valid, regdest}.
  - Every edge: entry[i] ← entry[i-1], and entry[0] ← {iss_mul_oper & (iss_mul_regdest≠0), iss_mul_regdest}.
  - The oldest entry drops out unconditionally. Shifting is never stalled, because the pipeline has no backpressure.
- **Hazard.** `mul_hazard` = OR over valid entries of (regdest==dec_rs_addr | regdest==dec_rt_addr). Register 0 never hazards.
  - Destinations of multiplies that overflow and are dropped by writeback still hazard until they age out. This is deliberately conservative.
- `mul_inflight` = popcount of valid entries.

## Timing
- Issue at edge N. Then:
  - `m1_m2_*` is valid after edge N.
  - The tracker entry is valid after N and remains valid after edges N+1 and N+2.
  - The entry is invalid after N+3, which is the cycle the writeback output carries the result.
  - `mul_hazard` therefore blocks decode for exactly 3 cycles after issue.
- Back-to-back issues every cycle are supported. `mul_inflight` saturates naturally at 3, with no overflow.
- Two issues to the same regdest occupy two entries. The hazard persists until the younger entry ages out.
- Synchronous reset mid-stream clears all entries at that edge. Operations already past M1 are not tracked by this block after reset.

## Structure
- Shared package `mult_pkg`:
  - `MUL_DEPTH` = 3
  - `REG_ZERO` = 5'd0
  - `mult_dest_t` struct {valid, regdest[4:0]}
  - function `mag_of(value)` for the sign/magnitude conversion.
- One natural sub-module, `mult_dest_tracker`: the shift register plus the match/popcount logic, parameterised by DEPTH. The top level holds the stage register and the conversion logic.

## Test plan
- Issue rs=-6 (0xFFFF_FFFA), rt=7, dest 9 → next cycle `m1_m2_oper`=1, rs_mag=6, rt_mag=7, ispositive=0, iszero=0, regdest=9.
- Issue rs=0x8000_0000, rt=-1 → rs_mag=0x8000_0000, rt_mag=1, ispositive=1. Issue rs=0, rt=-5 → iszero=1, ispositive=1.
- Issue dest 12, hold dec_rs_addr=12 → `mul_hazard`=1 for 3 cycles after the issue edge, 0 on the 4th. Dest 0 with dec_rs_addr=0 → `mul_hazard` stays 0.
- Issue 4 consecutive cycles (dests 1,2,3,4) → `mul_inflight` reads 1,2,3,3, then 2,1,0 after issue stops. dec_rt_addr=1 hazard clears when dest 1 ages out.
- Assert `reset`=0 while `mul_inflight`=3 and `iss_mul_oper`=1 → after that edge all outputs are 0 and `mul_hazard`=0 for any decode address.
- Idle cycle after a valid issue → all `m1_m2_*` are 0; random signed-operand sweep checks magnitude and sign against a reference model.
